// File: rtl/rasterizador_triangulo_if.sv
// ---------------------------------------------------------------------------
// rasterizador_triangulo_if
// Groups the job request and the pixel stream of the triangle rasterizer.
//   start                : request a job (sampled only while the rasterizer is idle)
//   px1..py3             : the three vertex coordinates (unsigned, W bits)
//   out_ready            : downstream accepts the current beat
//   out_valid            : a pixel beat is present on out_x/out_y/out_inside
//   out_x, out_y         : coordinate of the pixel being scanned
//   out_inside           : pixel lies inside or on an edge of the triangle
//   busy                 : rasterizer is not idle
//   done                 : one-cycle pulse after the final beat is accepted
//   inside_count         : accepted beats flagged inside in the current/last job
// master = job requester / stream consumer, slave = rasterizer.
// ---------------------------------------------------------------------------
interface rasterizador_triangulo_if #(
  parameter int W = 12
);
  logic           start;
  logic [W-1:0]   px1, py1, px2, py2, px3, py3;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_x, out_y;
  logic           out_inside;
  logic           busy;
  logic           done;
  logic [2*W:0]   inside_count;

  modport master (
    output start, px1, py1, px2, py2, px3, py3, out_ready,
    input  out_valid, out_x, out_y, out_inside, busy, done, inside_count
  );

  modport slave (
    input  start, px1, py1, px2, py2, px3, py3, out_ready,
    output out_valid, out_x, out_y, out_inside, busy, done, inside_count
  );
endinterface

// File: rtl/rasterizador_triangulo.sv
// ---------------------------------------------------------------------------
// rasterizador_triangulo
// Scans the bounding box of a triangle in row-major order and streams one
// beat per pixel, flagging pixels inside or on an edge of the triangle.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rasterizador_triangulo_if.slave (job request + pixel stream)
// Flow: IDLE --start--> SETUP (bounding box) --> SCAN (beats) --> DONE --> IDLE
// ---------------------------------------------------------------------------
module rasterizador_triangulo #(
  parameter int W = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  rasterizador_triangulo_if.slave     bus
);

  // Edge values need 2W+3 signed bits; one extra bit of headroom is kept.
  localparam int EW = 2 * W + 4;
  localparam int CW = 2 * W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    vx_q [3];
  logic [W-1:0]    vy_q [3];
  logic [W-1:0]    vx_d [3];
  logic [W-1:0]    vy_d [3];
  logic [W-1:0]    xmin_q, xmax_q, ymin_q, ymax_q;
  logic [W-1:0]    xmin_d, xmax_d, ymin_d, ymax_d;
  logic [W-1:0]    x_q, y_q, x_d, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    px_in [3];
  logic [W-1:0]    py_in [3];
  logic [W-1:0]    bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic [2:0]      e_nonneg, e_nonpos;
  logic            inside_raw;

  assign px_in[0] = bus.px1;
  assign px_in[1] = bus.px2;
  assign px_in[2] = bus.px3;
  assign py_in[0] = bus.py1;
  assign py_in[1] = bus.py2;
  assign py_in[2] = bus.py3;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Zero-extend an unsigned coordinate into the signed edge domain.
  function automatic logic signed [EW-1:0] zx(input logic [W-1:0] v);
    return $signed({{(EW - W){1'b0}}, v});
  endfunction

  assign bb_xmin = min3(vx_q[0], vx_q[1], vx_q[2]);
  assign bb_xmax = max3(vx_q[0], vx_q[1], vx_q[2]);
  assign bb_ymin = min3(vy_q[0], vy_q[1], vy_q[2]);
  assign bb_ymax = max3(vy_q[0], vy_q[1], vy_q[2]);

  // One edge function per triangle side: (1->2), (2->3), (3->1).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      localparam int NB = (gi + 1) % 3;
      logic signed [EW-1:0] dx_edge, dy_edge, dx_pix, dy_pix, e_val;

      assign dx_edge = zx(vx_q[NB]) - zx(vx_q[gi]);
      assign dy_edge = zx(vy_q[NB]) - zx(vy_q[gi]);
      assign dx_pix  = zx(x_q) - zx(vx_q[gi]);
      assign dy_pix  = zx(y_q) - zx(vy_q[gi]);
      assign e_val   = (dx_edge * dy_pix) - (dy_edge * dx_pix);

      assign e_nonneg[gi] = ~e_val[EW-1];
      assign e_nonpos[gi] = e_val[EW-1] | (e_val == '0);
    end
  endgenerate

  // Same sign on all three edges (zero counts for both) -> inside, whatever
  // the winding. Degenerate triangles fall out of the same test.
  assign inside_raw = (&e_nonneg) | (&e_nonpos);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= vx_d[i];
        vy_q[i] <= vy_d[i];
      end
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < 3; i++) begin
      vx_d[i] = vx_q[i];
      vy_d[i] = vy_q[i];
    end
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 3; i++) begin
            vx_d[i] = px_in[i];
            vy_d[i] = py_in[i];
          end
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        xmin_d  = bb_xmin;
        xmax_d  = bb_xmax;
        ymin_d  = bb_ymin;
        ymax_d  = bb_ymax;
        x_d     = bb_xmin;
        y_d     = bb_ymin;
        state_d = SCAN;
      end
      SCAN: begin
        if (bus.out_ready) begin
          if (inside_raw) begin
            cnt_d = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
          end
          // Compare against the box limits before stepping so the
          // position never wraps at the top of the coordinate range.
          if (x_q == xmax_q) begin
            if (y_q == ymax_q) begin
              state_d = DONE;
            end else begin
              x_d = xmin_q;
              y_d = y_q + {{(W - 1){1'b0}}, 1'b1};
            end
          end else begin
            x_d = x_q + {{(W - 1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_valid    = (state_q == SCAN);
  assign bus.out_x        = x_q;
  assign bus.out_y        = y_q;
  // Gated so the flag is quiet outside SCAN (e.g. all-zero vertices after reset).
  assign bus.out_inside   = (state_q == SCAN) & inside_raw;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.inside_count = cnt_q;

endmodule
